// File: rtl/gpr_modport_pkg.sv
// gpr_modport_pkg
// Shared CPU constants used by the general-purpose register file.
//   GPR_NUM      : number of general-purpose registers
//   GPR_ADDR_W   : register address width (GPR_NUM == 2**GPR_ADDR_W)
//   WORD_DATA_W  : machine word width
//   ENABLE_      : active-low enable encoding (0 = asserted)
//   DISABLE_     : active-low enable encoding (1 = deasserted)
//   RESET_ENABLE_: level of the active-low reset that clears state
package gpr_modport_pkg;

    localparam int GPR_NUM     = 32;
    localparam int GPR_ADDR_W  = 5;
    localparam int WORD_DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic RESET_ENABLE_ = 1'b0;

endpackage

// File: rtl/gpr_modport.sv
// gpr_modport
// General-purpose register file: NUM_REGS words of DATA_W bits, two
// combinational read ports and one synchronous write port with
// same-cycle write-to-read forwarding.
//
// Ports:
//   clk        : system clock, state updates on the rising edge
//   rst        : asynchronous active-low reset, clears every register
//   rd_addr_0  : read port 0 address
//   rd_data_0  : read port 0 data (combinational)
//   rd_addr_1  : read port 1 address
//   rd_data_1  : read port 1 data (combinational)
//   wr_addr    : write address
//   wr_data    : write data
//   wr_we_     : write enable, active-low (0 = write)
//
// NUM_REGS must equal 2**ADDR_W so every address selects a real register.
module gpr_modport
    import gpr_modport_pkg::*;
#(
    parameter int NUM_REGS = GPR_NUM,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int DATA_W   = WORD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_0,
    output logic [DATA_W-1:0] rd_data_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_we_
);

    logic [DATA_W-1:0] gpr [NUM_REGS];

    logic write_on;
    logic fwd_0;
    logic fwd_1;

    // Reset has priority over a write landing on the same edge, so a
    // register targeted while rst is low stays cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE_) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_we_ != DISABLE_) begin
            gpr[wr_addr] <= wr_data;
        end
    end

    // Forwarding ignores reset on purpose: the bypass is pure wiring from
    // the write bus, so a matching read shows wr_data even while rst is low.
    always_comb begin
        write_on  = (wr_we_ == ENABLE_);
        fwd_0     = write_on && (rd_addr_0 == wr_addr);
        fwd_1     = write_on && (rd_addr_1 == wr_addr);
        rd_data_0 = fwd_0 ? wr_data : gpr[rd_addr_0];
        rd_data_1 = fwd_1 ? wr_data : gpr[rd_addr_1];
    end

endmodule

// File: tb/tb_gpr_modport.sv
// tb_gpr_modport
// Self-checking bench for gpr_modport: a table of directed vectors, hand
// sequences for reset interaction, and a randomized run checked against a
// simple array model of the register file.
module tb_gpr_modport;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rd_addr_0;
    logic [DW-1:0] rd_data_0;
    logic [AW-1:0] rd_addr_1;
    logic [DW-1:0] rd_data_1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_we_;

    int total;
    int bad;

    // Reference contents of the register file.
    logic [DW-1:0] model [NREG];

    typedef struct {
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          we;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t vecs [13];

    gpr_modport #(
        .NUM_REGS(NREG),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_0(rd_addr_0),
        .rd_data_0(rd_data_0),
        .rd_addr_1(rd_addr_1),
        .rd_data_1(rd_data_1),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_we_   (wr_we_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected read value from the model and the current write bus.
    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] ra);
        if (wr_we_ == 1'b0 && ra == wr_addr) return wr_data;
        return model[ra];
    endfunction

    // Drive a full set of inputs on the falling edge, settle before checks.
    task automatic applyStimulus(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic we);
        @(negedge clk);
        rd_addr_0 = ra0;
        rd_addr_1 = ra1;
        wr_addr   = wa;
        wr_data   = wd;
        wr_we_    = we;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] exp0,
                               input logic [DW-1:0] exp1);
        total++;
        if (rd_data_0 !== exp0) begin
            bad++;
            $display("[TB] FAIL %s port0: actual=%h required=%h", name, rd_data_0, exp0);
        end
        total++;
        if (rd_data_1 !== exp1) begin
            bad++;
            $display("[TB] FAIL %s port1: actual=%h required=%h", name, rd_data_1, exp1);
        end
    endtask

    // Advance through a rising edge and let the model follow the write rule.
    task automatic clockEdge();
        logic          do_wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        do_wr = (rst == 1'b1) && (wr_we_ == 1'b0);
        wa    = wr_addr;
        wd    = wr_data;
        @(posedge clk);
        if (do_wr) model[wa] = wd;
    endtask

    task automatic clearModel();
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_we_    = 1'b1;
        clearModel();

        vecs[0]  = '{5'd5,  5'd6,  5'd5,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{5'd5,  5'd6,  5'd0,  32'h0,        1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{5'd7,  5'd7,  5'd7,  32'h11111111, 1'b0, 32'h11111111, 32'h11111111};
        vecs[3]  = '{5'd7,  5'd7,  5'd7,  32'h22222222, 1'b0, 32'h22222222, 32'h22222222};
        vecs[4]  = '{5'd7,  5'd7,  5'd7,  32'h33333333, 1'b1, 32'h22222222, 32'h22222222};
        vecs[5]  = '{5'd3,  5'd7,  5'd3,  32'hFFFFFFFF, 1'b1, 32'h0,        32'h22222222};
        vecs[6]  = '{5'd3,  5'd3,  5'd0,  32'h0,        1'b1, 32'h0,        32'h0};
        vecs[7]  = '{5'd0,  5'd31, 5'd0,  32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{5'd0,  5'd31, 5'd31, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[9]  = '{5'd31, 5'd0,  5'd1,  32'h0,        1'b1, 32'h5A5A5A5A, 32'hA5A5A5A5};
        vecs[10] = '{5'd12, 5'd12, 5'd12, 32'h00000001, 1'b0, 32'h00000001, 32'h00000001};
        vecs[11] = '{5'd12, 5'd0,  5'd12, 32'h00000002, 1'b0, 32'h00000002, 32'hA5A5A5A5};
        vecs[12] = '{5'd12, 5'd12, 5'd12, 32'h00000003, 1'b1, 32'h00000002, 32'h00000002};

        // Hold reset for a few cycles, then release on a falling edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(5'd0, 5'd31, 5'd0, 32'h0, 1'b1);
        checkOutput("reset_state", 32'h0, 32'h0);
        clockEdge();

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].ra0, vecs[i].ra1, vecs[i].wa, vecs[i].wd, vecs[i].we);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1);
            clockEdge();
        end

        // Reset asserted between edges while a write targets r9: the bypass
        // still shows the data, but nothing is stored.
        applyStimulus(5'd9, 5'd5, 5'd9, 32'h12345678, 1'b0);
        rst = 1'b0;
        #1;
        clearModel();
        checkOutput("rst_fwd", 32'h12345678, 32'h0);
        clockEdge();
        @(negedge clk);
        rst    = 1'b1;
        wr_we_ = 1'b1;
        #1;
        checkOutput("rst_r9_cleared", 32'h0, 32'h0);

        // Every address on both ports reads zero after reset.
        for (int a = 0; a < NREG; a++) begin
            rd_addr_0 = AW'(a);
            rd_addr_1 = AW'(NREG - 1 - a);
            #1;
            checkOutput($sformatf("rst_all_%0d", a), 32'h0, 32'h0);
        end
        clockEdge();

        // First enabled edge after release is a normal write.
        applyStimulus(5'd9, 5'd8, 5'd9, 32'hCAFEF00D, 1'b0);
        clockEdge();
        applyStimulus(5'd9, 5'd9, 5'd9, 32'h0, 1'b1);
        checkOutput("post_rst_write", 32'hCAFEF00D, 32'hCAFEF00D);
        clockEdge();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra0;
            logic [AW-1:0] ra1;
            logic [AW-1:0] wa;
            logic [DW-1:0] wd;
            logic          we;
            wa  = AW'($urandom_range(0, NREG - 1));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            wd  = $urandom;
            we  = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            applyStimulus(ra0, ra1, wa, wd, we);
            checkOutput($sformatf("rand%0d", n), expect_read(ra0), expect_read(ra1));
            clockEdge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_modport.md
# gpr_modport

General-purpose register file for the CPU core: NUM_REGS words of DATA_W bits, two combinational read ports and one synchronous write port. It sits between decode (read-port master) and write-back (write-port master). Same-cycle write-to-read forwarding means a register written this cycle reads back its new value without a stall.

## Interface
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, word width.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- rd_addr_0  input  ADDR_W  read port 0 address.
- rd_data_0  output  DATA_W  read port 0 data, combinational.
- rd_addr_1  input  ADDR_W  read port 1 address.
- rd_data_1  output  DATA_W  read port 1 data, combinational.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_we_  input  1  write enable, active-low (0 = write).

## Operation
- Storage: array gpr[0..NUM_REGS-1] of DATA_W bits. No register is hardwired; r0 is writable like any other.
- Write: on rising clk with rst high and wr_we_ == 0, gpr[wr_addr] <= wr_data. When wr_we_ == 1, no state changes.
- Read port n (n = 0, 1): rd_data_n = wr_data when (wr_we_ == 0 and rd_addr_n == wr_addr); otherwise gpr[rd_addr_n].
- Forwarding is purely combinational. It applies to both ports independently, including when both ports and the write address are the same register.
- Ports are fully independent. Both read ports may address the same register; each returns the identical value.
- No address decoding errors are possible, since NUM_REGS = 2**ADDR_W covers the full address space.

## Timing
- Reset: while rst == 0, every gpr entry is asynchronously cleared to 0. Reset overrides any write in the same cycle.
- Read outputs are not registered and have no dedicated reset value. After reset releases with wr_we_ == 1, every rd_data_n reads 0.
- The forwarding path stays active during reset. With rst == 0, wr_we_ == 0 and matching addresses, rd_data_n shows wr_data, but nothing is stored.
- Read latency: 0 cycles (combinational from rd_addr_n, wr_addr, wr_data, wr_we_ and array contents).
- Write latency: the value is visible from storage on the cycle after the edge. In the write cycle itself it is visible via forwarding.
- Back-to-back writes to the same address on consecutive cycles: the later write wins. A read in the second cycle forwards the second value.
- Reset released mid-stream: the first rising edge with rst high and wr_we_ == 0 performs a normal write.
- No handshake; a write is accepted every cycle it is enabled.

## Structure
- A shared cpu package holds: GPR_NUM, GPR_ADDR_W, WORD_DATA_W, the ENABLE_/DISABLE_ encodings (0/1), and the reset-polarity constants.
- Ports may be bundled as a read bus (two addresses in, two data out) and a write bus (address, data, we_), each with master/slave modports. The slave side maps 1:1 to the flat ports above.
- Single module with no sub-modules. The read mux with forwarding compare may be a local function, instantiated once per port.

## Test plan
- Reset: assert rst = 0 mid-run after writes, release, then read all 32 addresses on both ports -> every rd_data = 0.
- Basic write/read:
  - write 0xDEADBEEF to r5; next cycle rd_addr_0 = 5 -> 0xDEADBEEF.
  - rd_addr_1 = 6 -> 0.
- Forwarding: r7 holds 0x11111111; in one cycle drive wr_we_ = 0, wr_addr = 7, wr_data = 0x22222222, rd_addr_0 = rd_addr_1 = 7.
  - Same cycle: both read ports -> 0x22222222.
  - Next cycle with wr_we_ = 1: both -> 0x22222222.
- Disabled write: wr_we_ = 1, wr_addr = 3, wr_data = 0xFFFFFFFF, rd_addr_0 = 3 -> old value (0). r3 is unchanged afterwards.
- Register 0 and top register:
  - write 0xA5A5A5A5 to r0 -> r0 reads 0xA5A5A5A5.
  - write 0x5A5A5A5A to r31 -> r31 reads 0x5A5A5A5A.
- Async reset vs write: assert rst = 0 between edges while wr_we_ = 0 targets r9 with 0x12345678.
  - rd_data_0 (addr 9) shows 0x12345678 via forwarding.
  - After release with wr_we_ = 1, r9 reads 0.
